// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// ----------------
// Request/grant owner arbiter for a shared polynomial RAM that has separate
// read and write ports. One client at a time owns the RAM. The owner's write
// and read controls are muxed onto the RAM. An optional idle gap separates
// consecutive owners. Read data is tagged so it returns to the client that
// issued the read, even after ownership has moved on. A write from a client
// without a grant is blocked and counted.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req[N]            per-client ownership request (level)
//   rel[N]            per-client release pulse (only the owner's bit matters)
//   cl_wen/cl_waddr/cl_wdata   per-client write port (packed, client i at slice i)
//   cl_ren/cl_raddr   per-client read strobe and address (packed)
//   gnt[N]            registered one-hot grant
//   ram_wen/ram_waddr/ram_wdata/ram_raddr   to RAM
//   ram_rdata         from RAM
//   rdata             ram_rdata broadcast to all clients
//   rvalid[N]         one-hot owner of the current rdata
//   busy              FSM not idle, or reads still in flight
//   viol              one-cycle pulse after an illegal write attempt
//   viol_cnt          saturating count of illegal write cycles
module ram_port_arbiter #(
    parameter int N_CLIENTS = 5,
    parameter int DATA_W    = 96,
    parameter int ADDR_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int TURN_CYC  = 1,
    parameter int RR        = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CLIENTS-1:0]          req,
    input  logic [N_CLIENTS-1:0]          rel,
    input  logic [N_CLIENTS-1:0]          cl_wen,
    input  logic [N_CLIENTS*ADDR_W-1:0]   cl_waddr,
    input  logic [N_CLIENTS*DATA_W-1:0]   cl_wdata,
    input  logic [N_CLIENTS-1:0]          cl_ren,
    input  logic [N_CLIENTS*ADDR_W-1:0]   cl_raddr,
    output logic [N_CLIENTS-1:0]          gnt,
    output logic                          ram_wen,
    output logic [ADDR_W-1:0]             ram_waddr,
    output logic [DATA_W-1:0]             ram_wdata,
    output logic [ADDR_W-1:0]             ram_raddr,
    input  logic [DATA_W-1:0]             ram_rdata,
    output logic [DATA_W-1:0]             rdata,
    output logic [N_CLIENTS-1:0]          rvalid,
    output logic                          busy,
    output logic                          viol,
    output logic [7:0]                    viol_cnt
);

    localparam int PTR_W = $clog2(N_CLIENTS);
    // Index of the final idle cycle between owners; unused when TURN_CYC is 0.
    localparam logic [1:0] TURN_LAST = (TURN_CYC > 0) ? 2'(TURN_CYC - 1) : 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    state_t               r_state, w_state_next;
    logic [N_CLIENTS-1:0] r_gnt, w_gnt_next;
    logic [PTR_W-1:0]     r_owner, w_owner_next;
    logic [PTR_W-1:0]     r_ptr, w_ptr_next;
    logic [1:0]           r_turn_cnt, w_turn_cnt_next;

    logic [ADDR_W-1:0]    r_waddr, r_raddr;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_viol;
    logic [7:0]           r_viol_cnt;

    logic [RD_LAT-1:0]    r_tag_vld;
    logic [PTR_W-1:0]     r_tag_idx [RD_LAT];

    // Per-client views of the packed buses.
    logic [ADDR_W-1:0]    w_waddr_arr [N_CLIENTS];
    logic [DATA_W-1:0]    w_wdata_arr [N_CLIENTS];
    logic [ADDR_W-1:0]    w_raddr_arr [N_CLIENTS];

    genvar gi;
    generate
        for (gi = 0; gi < N_CLIENTS; gi++) begin : g_unpack
            assign w_waddr_arr[gi] = cl_waddr[gi*ADDR_W +: ADDR_W];
            assign w_wdata_arr[gi] = cl_wdata[gi*DATA_W +: DATA_W];
            assign w_raddr_arr[gi] = cl_raddr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Winner selection. Round-robin scans from r_ptr upward with wrap;
    // fixed priority scans from index 0.
    // ------------------------------------------------------------------
    logic                 w_arb_found;
    logic [PTR_W-1:0]     w_arb_idx;
    logic [PTR_W-1:0]     w_arb_ptr;
    logic [N_CLIENTS-1:0] w_arb_gnt;
    logic [PTR_W:0]       w_sum;
    logic [PTR_W-1:0]     w_cand;

    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        w_sum       = '0;
        w_cand      = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(N_CLIENTS)) begin
                w_sum = w_sum - (PTR_W+1)'(N_CLIENTS);
            end
            w_cand = (RR != 0) ? w_sum[PTR_W-1:0] : PTR_W'(k);
            if (!w_arb_found && req[w_cand]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_cand;
            end
        end
    end

    assign w_arb_ptr = (w_arb_idx == PTR_W'(N_CLIENTS - 1)) ? '0 : w_arb_idx + 1'b1;
    assign w_arb_gnt = w_arb_found ? (N_CLIENTS'(1) << w_arb_idx) : '0;

    // ------------------------------------------------------------------
    // Ownership FSM
    // ------------------------------------------------------------------
    logic w_own;
    logic w_owner_exit;
    logic w_arb_take;

    assign w_own        = (r_state == ST_OWN);
    // rel beats a still-high req from the owner.
    assign w_owner_exit = rel[r_owner] | ~req[r_owner];

    always_comb begin
        w_state_next    = r_state;
        w_gnt_next      = r_gnt;
        w_owner_next    = r_owner;
        w_ptr_next      = r_ptr;
        w_turn_cnt_next = r_turn_cnt;
        w_arb_take      = 1'b0;

        case (r_state)
            ST_IDLE: w_arb_take = 1'b1;
            ST_OWN: begin
                if (w_owner_exit) begin
                    if (TURN_CYC > 0) begin
                        w_state_next    = ST_TURN;
                        w_gnt_next      = '0;
                        w_turn_cnt_next = 2'd0;
                    end else begin
                        w_arb_take = 1'b1;
                    end
                end
            end
            ST_TURN: begin
                // Arbitrate on the last idle cycle so exactly TURN_CYC
                // grant-free cycles separate two owners.
                if (r_turn_cnt == TURN_LAST) begin
                    w_arb_take = 1'b1;
                end else begin
                    w_turn_cnt_next = r_turn_cnt + 2'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_gnt_next   = '0;
            end
        endcase

        if (w_arb_take) begin
            w_state_next = w_arb_found ? ST_OWN : ST_IDLE;
            w_gnt_next   = w_arb_gnt;
            if (w_arb_found) begin
                w_owner_next = w_arb_idx;
                w_ptr_next   = w_arb_ptr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Violations: any write enable without a grant, counted once per cycle.
    // ------------------------------------------------------------------
    logic w_viol_now;
    logic w_rd_issue;

    assign w_viol_now = |(cl_wen & ~r_gnt);
    assign w_rd_issue = w_own & cl_ren[r_owner];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_gnt        <= '0;
            r_owner      <= '0;
            r_ptr        <= '0;
            r_turn_cnt   <= 2'd0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_raddr      <= '0;
            r_viol       <= 1'b0;
            r_viol_cnt   <= 8'd0;
            r_tag_vld[0] <= 1'b0;
            r_tag_idx[0] <= '0;
        end else begin
            r_state      <= w_state_next;
            r_gnt        <= w_gnt_next;
            r_owner      <= w_owner_next;
            r_ptr        <= w_ptr_next;
            r_turn_cnt   <= w_turn_cnt_next;
            // Remember the owner's controls so the RAM address/data lines
            // hold still while nobody owns the RAM.
            if (w_own) begin
                r_waddr <= w_waddr_arr[r_owner];
                r_wdata <= w_wdata_arr[r_owner];
                r_raddr <= w_raddr_arr[r_owner];
            end
            r_viol <= w_viol_now;
            if (w_viol_now && (r_viol_cnt != 8'hFF)) begin
                r_viol_cnt <= r_viol_cnt + 8'd1;
            end
            r_tag_vld[0] <= w_rd_issue;
            r_tag_idx[0] <= r_owner;
        end
    end

    // Remaining stages of the read tag pipe, matching the RAM read latency.
    generate
        for (gi = 1; gi < RD_LAT; gi++) begin : g_tag_pipe
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_tag_vld[gi] <= 1'b0;
                    r_tag_idx[gi] <= '0;
                end else begin
                    r_tag_vld[gi] <= r_tag_vld[gi-1];
                    r_tag_idx[gi] <= r_tag_idx[gi-1];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gnt       = r_gnt;
    assign ram_wen   = w_own & cl_wen[r_owner];
    assign ram_waddr = w_own ? w_waddr_arr[r_owner] : r_waddr;
    assign ram_wdata = w_own ? w_wdata_arr[r_owner] : r_wdata;
    assign ram_raddr = w_own ? w_raddr_arr[r_owner] : r_raddr;
    assign rdata     = ram_rdata;
    assign rvalid    = r_tag_vld[RD_LAT-1] ? (N_CLIENTS'(1) << r_tag_idx[RD_LAT-1]) : '0;
    assign busy      = (r_state != ST_IDLE) | (|r_tag_vld);
    assign viol      = r_viol;
    assign viol_cnt  = r_viol_cnt;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter. Two instances share one stimulus:
//   u_a : defaults (RR=1, RD_LAT=1, TURN_CYC=1)
//   u_b : fixed priority, RD_LAT=3, TURN_CYC=1
// Each instance has its own simple RAM model. Inputs change on the falling
// edge; outputs are checked 1 time unit later.
module tb_ram_port_arbiter;

    localparam int N  = 5;
    localparam int DW = 96;
    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N-1:0]      req, rel, cl_wen, cl_ren;
    logic [N*AW-1:0]   cl_waddr, cl_raddr;
    logic [N*DW-1:0]   cl_wdata;

    logic [N-1:0]      a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic              a_ram_wen, a_busy, a_viol, b_ram_wen, b_busy, b_viol;
    logic [AW-1:0]     a_ram_waddr, a_ram_raddr, b_ram_waddr, b_ram_raddr;
    logic [DW-1:0]     a_ram_wdata, a_ram_rdata, a_rdata;
    logic [DW-1:0]     b_ram_wdata, b_ram_rdata, b_rdata;
    logic [7:0]        a_viol_cnt, b_viol_cnt;

    ram_port_arbiter u_a (
        .clk(clk), .rst(rst), .req(req), .rel(rel), .cl_wen(cl_wen),
        .cl_waddr(cl_waddr), .cl_wdata(cl_wdata), .cl_ren(cl_ren), .cl_raddr(cl_raddr),
        .gnt(a_gnt), .ram_wen(a_ram_wen), .ram_waddr(a_ram_waddr), .ram_wdata(a_ram_wdata),
        .ram_raddr(a_ram_raddr), .ram_rdata(a_ram_rdata), .rdata(a_rdata), .rvalid(a_rvalid),
        .busy(a_busy), .viol(a_viol), .viol_cnt(a_viol_cnt)
    );

    ram_port_arbiter #(.RR(0), .RD_LAT(3), .TURN_CYC(1)) u_b (
        .clk(clk), .rst(rst), .req(req), .rel(rel), .cl_wen(cl_wen),
        .cl_waddr(cl_waddr), .cl_wdata(cl_wdata), .cl_ren(cl_ren), .cl_raddr(cl_raddr),
        .gnt(b_gnt), .ram_wen(b_ram_wen), .ram_waddr(b_ram_waddr), .ram_wdata(b_ram_wdata),
        .ram_raddr(b_ram_raddr), .ram_rdata(b_ram_rdata), .rdata(b_rdata), .rvalid(b_rvalid),
        .busy(b_busy), .viol(b_viol), .viol_cnt(b_viol_cnt)
    );

    // RAM models: latency 1 for u_a, latency 3 for u_b.
    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];
    logic [DW-1:0] b_p1, b_p2;

    always @(posedge clk) begin
        if (a_ram_wen) mem_a[a_ram_waddr] <= a_ram_wdata;
        a_ram_rdata <= mem_a[a_ram_raddr];
        if (b_ram_wen) mem_b[b_ram_waddr] <= b_ram_wdata;
        b_p1        <= mem_b[b_ram_raddr];
        b_p2        <= b_p1;
        b_ram_rdata <= b_p2;
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        req = '0; rel = '0; cl_wen = '0; cl_ren = '0;
        cl_waddr = '0; cl_raddr = '0; cl_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [N-1:0] exp_g;

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        // Reset state
        chk("rst_gnt",      a_gnt, 5'b0);
        chk("rst_ram_wen",  a_ram_wen, 1'b0);
        chk("rst_waddr",    a_ram_waddr, 8'h0);
        chk("rst_wdata",    a_ram_wdata, 96'h0);
        chk("rst_raddr",    a_ram_raddr, 8'h0);
        chk("rst_rvalid",   a_rvalid, 5'b0);
        chk("rst_busy",     a_busy, 1'b0);
        chk("rst_viol",     a_viol, 1'b0);
        chk("rst_viol_cnt", a_viol_cnt, 8'd0);

        // ---- Grant, write, read-back on u_a (RD_LAT=1) ----
        @(negedge clk); rst = 1'b0; req = 5'b00100; #1;
        chk("s1_gnt_c0", a_gnt, 5'b00000);
        @(negedge clk); #1;
        chk("s1_gnt_c1", a_gnt, 5'b00100);
        cl_wen = 5'b00100; cl_waddr[2*AW +: AW] = 8'h10; cl_wdata[2*DW +: DW] = 96'hABC; #1;
        chk("s1_ram_wen",   a_ram_wen, 1'b1);
        chk("s1_ram_waddr", a_ram_waddr, 8'h10);
        chk("s1_ram_wdata", a_ram_wdata, 96'hABC);
        @(negedge clk); cl_wen = '0; cl_ren = 5'b00100; cl_raddr[2*AW +: AW] = 8'h10; #1;
        chk("s1_ram_raddr", a_ram_raddr, 8'h10);
        chk("s1_rvalid_c0", a_rvalid, 5'b0);
        @(negedge clk); cl_ren = '0; #1;
        chk("s1_rvalid_c1", a_rvalid, 5'b00100);
        chk("s1_rdata",     a_rdata, 96'hABC);
        chk("s1_busy",      a_busy, 1'b1);
        @(negedge clk); rel = 5'b00100; #1;
        chk("s1_rvalid_c2", a_rvalid, 5'b0);
        @(negedge clk); rel = '0; req = '0; cl_waddr[2*AW +: AW] = 8'h77; #1;
        chk("s1_turn_gnt",  a_gnt, 5'b0);
        chk("s1_turn_busy", a_busy, 1'b1);
        chk("s1_turn_wen",  a_ram_wen, 1'b0);
        chk("s1_hold_waddr", a_ram_waddr, 8'h10);
        @(negedge clk); #1;
        chk("s1_idle_gnt",  a_gnt, 5'b0);
        chk("s1_idle_busy", a_busy, 1'b0);

        // ---- Round robin on u_a: order 0,1,2,3,4,0 with one idle cycle ----
        do_reset();
        req = 5'b11111;
        for (int i = 0; i < 6; i++) begin
            exp_g = 5'b00001 << (i % 5);
            @(negedge clk); #1;
            chk("rr_gnt_a", a_gnt, exp_g);
            @(negedge clk); rel = exp_g; #1;
            chk("rr_gnt_b", a_gnt, exp_g);
            @(negedge clk); rel = '0; #1;
            chk("rr_gap", a_gnt, 5'b0);
        end

        // ---- Fixed priority on u_b ----
        do_reset();
        req = 5'b10110;
        @(negedge clk); #1;
        chk("fp_gnt1", b_gnt, 5'b00010);
        rel = 5'b00010; req = 5'b10100;
        @(negedge clk); rel = '0; #1;
        chk("fp_gap1", b_gnt, 5'b0);
        @(negedge clk); #1;
        chk("fp_gnt2", b_gnt, 5'b00100);
        @(negedge clk); #1;
        chk("fp_gnt2_hold", b_gnt, 5'b00100);
        rel = 5'b00100; req = 5'b10000;
        @(negedge clk); rel = '0; #1;
        chk("fp_gap2", b_gnt, 5'b0);
        @(negedge clk); #1;
        chk("fp_gnt4", b_gnt, 5'b10000);

        // ---- Violations and saturation on u_a ----
        do_reset();
        req = 5'b00001;
        @(negedge clk); #1;
        chk("v_gnt0", a_gnt, 5'b00001);
        cl_wen = 5'b01000; cl_waddr[3*AW +: AW] = 8'h33; #1;
        chk("v_blocked", a_ram_wen, 1'b0);
        @(negedge clk); cl_wen = '0; #1;
        chk("v_pulse", a_viol, 1'b1);
        chk("v_cnt1", a_viol_cnt, 8'd1);
        @(negedge clk); #1;
        chk("v_pulse_end", a_viol, 1'b0);
        cl_wen = 5'b01000;
        repeat (253) @(negedge clk);
        #1;
        chk("v_cnt254", a_viol_cnt, 8'd254);
        chk("v_blocked2", a_ram_wen, 1'b0);
        repeat (47) @(negedge clk);
        cl_wen = '0; #1;
        chk("v_cnt_sat", a_viol_cnt, 8'd255);

        // ---- RD_LAT=3 read tag survives ownership change on u_b ----
        do_reset();
        req = 5'b10010;
        @(negedge clk); #1;
        chk("t_gnt1", b_gnt, 5'b00010);
        cl_wen = 5'b00010; cl_waddr[1*AW +: AW] = 8'h20; cl_wdata[1*DW +: DW] = 96'h5A5;
        @(negedge clk);
        cl_wen = '0; cl_ren = 5'b00010; cl_raddr[1*AW +: AW] = 8'h20;
        rel = 5'b00010; req = 5'b10000; #1;
        chk("t_rvalid_c0", b_rvalid, 5'b0);
        @(negedge clk); cl_ren = '0; rel = '0; #1;
        chk("t_gap", b_gnt, 5'b0);
        chk("t_rvalid_c1", b_rvalid, 5'b0);
        chk("t_busy", b_busy, 1'b1);
        @(negedge clk); #1;
        chk("t_gnt4", b_gnt, 5'b10000);
        chk("t_rvalid_c2", b_rvalid, 5'b0);
        @(negedge clk); #1;
        chk("t_rvalid_c3", b_rvalid, 5'b00010);
        chk("t_rdata", b_rdata, 96'h5A5);
        chk("t_gnt4_hold", b_gnt, 5'b10000);
        @(negedge clk); #1;
        chk("t_rvalid_c4", b_rvalid, 5'b0);

        // ---- Reset while a read is in flight on u_b ----
        do_reset();
        req = 5'b00001;
        @(negedge clk); #1;
        chk("r_gnt0", b_gnt, 5'b00001);
        cl_wen = 5'b01000;
        @(negedge clk); cl_wen = '0; cl_ren = 5'b00001; cl_raddr[0 +: AW] = 8'h00; #1;
        chk("r_cnt1", b_viol_cnt, 8'd1);
        @(negedge clk); cl_ren = '0; rst = 1'b1; req = '0; #1;
        chk("r_busy_pre", b_busy, 1'b1);
        @(negedge clk); rst = 1'b0; #1;
        chk("r_gnt", b_gnt, 5'b0);
        chk("r_rvalid", b_rvalid, 5'b0);
        chk("r_busy", b_busy, 1'b0);
        chk("r_viol_cnt", b_viol_cnt, 8'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("r_no_rvalid", b_rvalid, 5'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Parametrised N-client arbiter for the shared single-port-pair polynomial RAM (separate read and write ports) used by the Kyber datapath. Clients are coder, NTT, add/sub, A generator, CBD and future units. It replaces the static controller-driven read/write selects with a request/grant ownership protocol, plus configurable turnaround. Read data is tagged back to the issuing client across ownership changes. Illegal writes from clients that do not own the RAM are detected and counted.

Parameters:
N_CLIENTS, 5, number of requesting clients (2..8)
DATA_W, 96, RAM word width
ADDR_W, 8, RAM address width
RD_LAT, 1, RAM read latency in cycles (1..4)
TURN_CYC, 1, idle cycles inserted between owners (0..3)
RR, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  N_CLIENTS  per-client ownership request (level)
rel  in  N_CLIENTS  per-client release pulse; only the owner's bit is honoured
cl_wen  in  N_CLIENTS  per-client write enable
cl_waddr  in  N_CLIENTS*ADDR_W  packed write addresses; client i occupies bits [i*ADDR_W +: ADDR_W]
cl_wdata  in  N_CLIENTS*DATA_W  packed write data
cl_ren  in  N_CLIENTS  per-client read strobe
cl_raddr  in  N_CLIENTS*ADDR_W  packed read addresses
gnt  out  N_CLIENTS  one-hot grant (registered)
ram_wen  out  1  to RAM write enable
ram_waddr  out  ADDR_W  to RAM
ram_wdata  out  DATA_W  to RAM
ram_raddr  out  ADDR_W  to RAM
ram_rdata  in  DATA_W  from RAM
rdata  out  DATA_W  ram_rdata passed through to all clients
rvalid  out  N_CLIENTS  one-hot; marks the client the current rdata belongs to
busy  out  1  high whenever the FSM is not in IDLE or reads are in flight
viol  out  1  one-cycle pulse on an illegal write attempt
viol_cnt  out  8  saturating count of illegal write attempts

Behaviour:
- Reset values: gnt=0, ram_wen=0, ram_waddr=0, ram_wdata=0, ram_raddr=0, rvalid=0, busy=0, viol=0, viol_cnt=0. The round-robin pointer resets to index 0, and the read tag pipeline is flushed.
- The FSM has three states: IDLE, OWN, TURN.
- IDLE: if any req bit is set, pick a winner and load gnt with its one-hot value on the next edge, entering OWN. First grant therefore arrives 1 cycle after req rises.
- Winner selection when RR=0: lowest set index.
- Winner selection when RR=1: first set index at or after ptr, wrapping modulo N_CLIENTS. After each grant, ptr becomes winner+1, wrapping modulo N_CLIENTS.
- OWN: ram_wen, ram_waddr and ram_wdata come combinationally from the owner's cl_* signals. ram_raddr is the owner's cl_raddr. A read issues only when cl_ren[owner]=1.
- OWN exit: leave when rel[owner]=1, or when req[owner] drops to 0. A write presented in the rel cycle is still performed.
  - Exit goes to TURN if TURN_CYC>0.
  - If TURN_CYC=0, exit goes to IDLE-arbitration in the same edge: gnt moves straight to the next winner, or clears if there is none.
- TURN: gnt=0 and ram_wen forced 0 for exactly TURN_CYC cycles, then return to IDLE.
- Outside OWN: ram_wen=0. ram_waddr, ram_wdata and ram_raddr hold their last driven values.
- Read tagging: each issued read pushes {valid, owner index} into an RD_LAT-deep shift register. rvalid[tag] asserts exactly RD_LAT cycles after the cl_ren cycle.
- Reads in flight complete to the original issuer even if ownership has since changed. busy stays high until the tag pipe is empty.
- Violation: cl_wen[i]=1 while gnt[i]=0 (in any state) is a violation. The write is blocked, viol pulses the next cycle, and viol_cnt increments, saturating at 255. Multiple simultaneous violators count as one.
- Non-owner cl_ren is ignored silently.
- Simultaneous events:
  - rel and req both high from the owner: rel wins.
  - rel high on a non-owner: ignored.
  - req rising during TURN: waits until IDLE arbitration.
- Mid-operation reset: an rst assertion in any state returns all state to reset values on that edge. In-flight reads are dropped with no rvalid.

Test Plan:
- RD_LAT=1, TURN_CYC=1: client 2 raises req at cycle 0 -> gnt=5'b00100 at cycle 1. Write 0xABC to addr 0x10, then read addr 0x10 -> rdata=0xABC with rvalid[2]=1 one cycle after cl_ren.
- RR=1, req=5'b11111 held, each owner pulses rel after 2 cycles -> grant order 0,1,2,3,4,0, with exactly one gnt=0 cycle between owners.
- RR=0, req=5'b10110 -> client 1 granted. After client 1 releases, client 2 is granted, never client 4 while client 2 requests.
- Client 3 asserts cl_wen while client 0 owns -> ram_wen=0, viol pulses once, viol_cnt=1. Repeating 300 times -> viol_cnt=255.
- RD_LAT=3: owner 1 reads in its rel cycle and client 4 is then granted -> rvalid=5'b00010 three cycles after the read, even though gnt=5'b10000 by then.
- rst asserted in OWN with a read in flight -> next cycle gnt=0, rvalid=0, busy=0, viol_cnt=0, and no rvalid pulse follows.
